// File: rtl/ppu_vaddr_scroll.sv
// PPU scroll/address register file: owns v, t, fine X, the write toggle and the
// PPUDATA increment mode. Optional build macro: PPU_PPUDATA_GLITCH_EN.
module ppu_vaddr_scroll (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [2:0]  reg_sel,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [7:0]  reg_wr_data,
    input  logic        render_en,
    input  logic        rendering,
    input  logic        h_scroll,
    input  logic        v_scroll,
    input  logic        h_update,
    input  logic        v_update,
    output logic [15:0] vAddr,
    output logic [2:0]  fX,
    output logic        w_toggle,
    output logic        inc32
);

    localparam logic [2:0] SEL_CTRL   = 3'd0;
    localparam logic [2:0] SEL_STATUS = 3'd2;
    localparam logic [2:0] SEL_SCROLL = 3'd5;
    localparam logic [2:0] SEL_ADDR   = 3'd6;
    localparam logic [2:0] SEL_DATA   = 3'd7;

    logic [14:0] v_q, v_d;
    logic [14:0] t_q, t_d;
    logic [2:0]  fx_q, fx_d;
    logic        w_q, w_d;
    logic        inc32_q, inc32_d;

    logic        cpu_wr_s, cpu_rd_s;
    logic        data_acc_s, v_load_s, glitch_s;
    logic        hs_s, vs_s, hu_s, vu_s, any_strobe_s;
    logic [14:0] v_x_s, v_y_s, v_scrolled_s;

    // Coarse X increment, wrapping into the horizontal nametable bit.
    function automatic logic [14:0] inc_x(input logic [14:0] v);
        logic [14:0] r;
        r = v;
        if (v[4:0] == 5'd31) begin
            r[4:0] = 5'd0;
            r[10]  = ~v[10];
        end else begin
            r[4:0] = v[4:0] + 5'd1;
        end
        return r;
    endfunction

    // Fine Y increment; coarse Y 29 wraps with a nametable flip, 31 wraps silently.
    function automatic logic [14:0] inc_y(input logic [14:0] v);
        logic [14:0] r;
        r = v;
        if (v[14:12] != 3'd7) begin
            r[14:12] = v[14:12] + 3'd1;
        end else begin
            r[14:12] = 3'd0;
            case (v[9:5])
                5'd29: begin
                    r[9:5] = 5'd0;
                    r[11]  = ~v[11];
                end
                5'd31:   r[9:5] = 5'd0;
                default: r[9:5] = v[9:5] + 5'd1;
            endcase
        end
        return r;
    endfunction

    // CPU register decode and next-state selection for v/t/fine X/toggle.
    always_comb begin
        v_d          = v_q;
        t_d          = t_q;
        fx_d         = fx_q;
        w_d          = w_q;
        inc32_d      = inc32_q;
        data_acc_s   = 1'b0;
        v_load_s     = 1'b0;
        v_x_s        = v_q;
        v_y_s        = v_q;
        v_scrolled_s = v_q;

        cpu_wr_s = clk_en & reg_wr;
        cpu_rd_s = clk_en & reg_rd & ~reg_wr;

        if (cpu_wr_s) begin
            case (reg_sel)
                SEL_CTRL: begin
                    t_d[11:10] = reg_wr_data[1:0];
                    inc32_d    = reg_wr_data[2];
                end
                SEL_SCROLL: begin
                    if (!w_q) begin
                        t_d[4:0] = reg_wr_data[7:3];
                        fx_d     = reg_wr_data[2:0];
                        w_d      = 1'b1;
                    end else begin
                        t_d[14:12] = reg_wr_data[2:0];
                        t_d[9:5]   = reg_wr_data[7:3];
                        w_d        = 1'b0;
                    end
                end
                SEL_ADDR: begin
                    if (!w_q) begin
                        t_d[13:8] = reg_wr_data[5:0];
                        t_d[14]   = 1'b0;
                        w_d       = 1'b1;
                    end else begin
                        t_d[7:0] = reg_wr_data;
                        v_load_s = 1'b1;
                        w_d      = 1'b0;
                    end
                end
                SEL_DATA: data_acc_s = 1'b1;
                default:  data_acc_s = 1'b0;
            endcase
        end else if (cpu_rd_s) begin
            case (reg_sel)
                SEL_STATUS: w_d        = 1'b0;
                SEL_DATA:   data_acc_s = 1'b1;
                default:    data_acc_s = 1'b0;
            endcase
        end else begin
            data_acc_s = 1'b0;
        end

`ifdef PPU_PPUDATA_GLITCH_EN
        glitch_s = data_acc_s & rendering;
`else
        glitch_s = 1'b0;
`endif

        hs_s = (clk_en & render_en & h_scroll) | glitch_s;
        vs_s = (clk_en & render_en & v_scroll) | glitch_s;
        hu_s = clk_en & render_en & h_update;
        vu_s = clk_en & render_en & v_update;
        any_strobe_s = hs_s | vs_s | hu_s | vu_s;

        // X and Y fields are disjoint, so each path is resolved independently.
        if (hu_s) begin
            v_x_s[10]  = t_q[10];
            v_x_s[4:0] = t_q[4:0];
        end else if (hs_s) begin
            v_x_s = inc_x(v_q);
        end else begin
            v_x_s = v_q;
        end

        if (vu_s) begin
            v_y_s[14:11] = t_q[14:11];
            v_y_s[9:5]   = t_q[9:5];
        end else if (vs_s) begin
            v_y_s = inc_y(v_q);
        end else begin
            v_y_s = v_q;
        end

        v_scrolled_s = {v_y_s[14:11], v_x_s[10], v_y_s[9:5], v_x_s[4:0]};

        if (v_load_s) begin
            v_d = t_d;
        end else if (any_strobe_s) begin
            v_d = v_scrolled_s;
        end else if (data_acc_s) begin
            v_d = v_q + (inc32_q ? 15'd32 : 15'd1);
        end else begin
            v_d = v_q;
        end
    end

`ifndef PPU_PPUDATA_GLITCH_EN
    logic unused_rendering_s;
    assign unused_rendering_s = rendering;
`endif

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q     <= 15'd0;
            t_q     <= 15'd0;
            fx_q    <= 3'd0;
            w_q     <= 1'b0;
            inc32_q <= 1'b0;
        end else begin
            v_q     <= v_d;
            t_q     <= t_d;
            fx_q    <= fx_d;
            w_q     <= w_d;
            inc32_q <= inc32_d;
        end
    end

    assign vAddr    = {1'b0, v_q};
    assign fX       = fx_q;
    assign w_toggle = w_q;
    assign inc32    = inc32_q;

endmodule

// File: tb/tb_ppu_vaddr_scroll.sv
// Scoreboard bench for ppu_vaddr_scroll: a field-level reference model predicts
// the outputs after every clock; a monitor compares them against the DUT.
module tb_ppu_vaddr_scroll;

    logic        clk = 1'b0;
    logic        rst, clk_en, reg_wr, reg_rd;
    logic [2:0]  reg_sel;
    logic [7:0]  reg_wr_data;
    logic        render_en, rendering, h_scroll, v_scroll, h_update, v_update;
    logic [15:0] vAddr;
    logic [2:0]  fX;
    logic        w_toggle, inc32;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] vaddr;
        logic [2:0]  fx;
        logic        w;
        logic        inc32;
    } exp_t;
    exp_t exp_q[$];

    int m_v, m_t, m_fx, m_w, m_inc32;

    always #5 clk = ~clk;

    ppu_vaddr_scroll dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .reg_sel(reg_sel),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_wr_data(reg_wr_data),
        .render_en(render_en), .rendering(rendering),
        .h_scroll(h_scroll), .v_scroll(v_scroll),
        .h_update(h_update), .v_update(v_update),
        .vAddr(vAddr), .fX(fX), .w_toggle(w_toggle), .inc32(inc32)
    );

    function automatic int pack_addr(int fy, int nty, int ntx, int cy, int cx);
        return fy * 4096 + nty * 2048 + ntx * 1024 + cy * 32 + cx;
    endfunction

    // Reference model: applies one sampled clock edge using field arithmetic.
    task automatic model_step();
        int d, tv, vv, cx, cy, ntx, nty, fy;
        bit wr, rd, data, hs, vs, hu, vu, vload;
        if (rst) begin
            m_v = 0; m_t = 0; m_fx = 0; m_w = 0; m_inc32 = 0;
            return;
        end
        if (!clk_en) return;
        d = int'(reg_wr_data); tv = m_t; vv = m_v;
        wr = reg_wr; rd = reg_rd && !reg_wr;
        data = 0; vload = 0;
        if (wr) begin
            case (reg_sel)
                3'd0: begin
                    tv = tv - ((tv / 1024) % 4) * 1024 + (d % 4) * 1024;
                    m_inc32 = (d / 4) % 2;
                end
                3'd5: begin
                    if (m_w == 0) begin
                        tv = tv - tv % 32 + d / 8;
                        m_fx = d % 8;
                        m_w = 1;
                    end else begin
                        tv = tv % 4096 - ((tv / 32) % 32) * 32 + (d / 8) * 32 + (d % 8) * 4096;
                        m_w = 0;
                    end
                end
                3'd6: begin
                    if (m_w == 0) begin
                        tv = tv % 256 + (d % 64) * 256;
                        m_w = 1;
                    end else begin
                        tv = tv - tv % 256 + d;
                        vload = 1;
                        m_w = 0;
                    end
                end
                3'd7: data = 1;
                default: data = 0;
            endcase
        end else if (rd) begin
            if (reg_sel == 3'd2) m_w = 0;
            if (reg_sel == 3'd7) data = 1;
        end
        hs = render_en && h_scroll;
        vs = render_en && v_scroll;
        hu = render_en && h_update;
        vu = render_en && v_update;
`ifdef PPU_PPUDATA_GLITCH_EN
        if (data && rendering) begin hs = 1; vs = 1; end
`endif
        cx = vv % 32; cy = (vv / 32) % 32; ntx = (vv / 1024) % 2;
        nty = (vv / 2048) % 2; fy = vv / 4096;
        if (hu || hs || vu || vs) begin
            if (hu) begin
                cx = m_t % 32; ntx = (m_t / 1024) % 2;
            end else if (hs) begin
                if (cx == 31) begin cx = 0; ntx = 1 - ntx; end
                else cx = cx + 1;
            end
            if (vu) begin
                cy = (m_t / 32) % 32; nty = (m_t / 2048) % 2; fy = m_t / 4096;
            end else if (vs) begin
                if (fy < 7) fy = fy + 1;
                else begin
                    fy = 0;
                    if (cy == 29) begin cy = 0; nty = 1 - nty; end
                    else if (cy == 31) cy = 0;
                    else cy = cy + 1;
                end
            end
            vv = pack_addr(fy, nty, ntx, cy, cx);
        end else if (data) begin
            vv = (vv + (m_inc32 != 0 ? 32 : 1)) % 32768;
        end
        if (vload) vv = tv;
        m_v = vv; m_t = tv;
    endtask

    task automatic step(input bit r, input bit ce, input logic [2:0] sel,
                        input bit wr, input bit rd, input logic [7:0] d,
                        input bit ren, input bit rend,
                        input bit hs, input bit vs, input bit hu, input bit vu);
        exp_t e;
        @(negedge clk);
        rst = r; clk_en = ce; reg_sel = sel; reg_wr = wr; reg_rd = rd;
        reg_wr_data = d; render_en = ren; rendering = rend;
        h_scroll = hs; v_scroll = vs; h_update = hu; v_update = vu;
        @(posedge clk);
        model_step();
        e.vaddr = 16'(m_v); e.fx = 3'(m_fx); e.w = m_w[0]; e.inc32 = m_inc32[0];
        exp_q.push_back(e);
    endtask

    task automatic cpu_write(input logic [2:0] sel, input logic [7:0] d);
        step(1'b0, 1'b1, sel, 1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cpu_read(input logic [2:0] sel);
        step(1'b0, 1'b1, sel, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobe(input bit hs, input bit vs, input bit hu, input bit vu);
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, hs, vs, hu, vu);
    endtask

    task automatic reset_cycle();
        step(1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    // Fixed-value check of the outputs just after the last edge.
    task automatic expect_out(input string name, input logic [15:0] ev,
                              input logic [2:0] efx, input logic ew);
        #2;
        checks++;
        if (vAddr !== ev || fX !== efx || w_toggle !== ew) begin
            failures++;
            $display("FAIL %s: got vAddr=%h fX=%0d w=%0b, want vAddr=%h fX=%0d w=%0b",
                     name, vAddr, fX, w_toggle, ev, efx, ew);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (vAddr !== e.vaddr || fX !== e.fx || w_toggle !== e.w || inc32 !== e.inc32) begin
                    failures++;
                    $display("FAIL scoreboard @%0t: got vAddr=%h fX=%0d w=%0b inc32=%0b, want vAddr=%h fX=%0d w=%0b inc32=%0b",
                             $time, vAddr, fX, w_toggle, inc32, e.vaddr, e.fx, e.w, e.inc32);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wait_cycles;
        rst = 1'b1; clk_en = 1'b0; reg_sel = 3'd0; reg_wr = 1'b0; reg_rd = 1'b0;
        reg_wr_data = 8'h00; render_en = 1'b0; rendering = 1'b0;
        h_scroll = 1'b0; v_scroll = 1'b0; h_update = 1'b0; v_update = 1'b0;

        reset_cycle();
        reset_cycle();
        expect_out("reset", 16'h0000, 3'd0, 1'b0);

        cpu_write(3'd5, 8'h7D);
        cpu_write(3'd5, 8'h5E);
        expect_out("scroll_pair_v_unchanged", 16'h0000, 3'd5, 1'b0);
        strobe(1'b0, 1'b0, 1'b1, 1'b1);
        expect_out("scroll_pair_t", 16'h616F, 3'd5, 1'b0);

        cpu_write(3'd6, 8'h21);
        cpu_write(3'd6, 8'h08);
        expect_out("addr_pair", 16'h2108, 3'd5, 1'b0);
        cpu_write(3'd0, 8'h04);
        cpu_read(3'd7);
        expect_out("data_inc32", 16'h2128, 3'd5, 1'b0);

        cpu_write(3'd6, 8'h00);
        cpu_write(3'd6, 8'h1F);
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("h_scroll_wrap", 16'h0400, 3'd5, 1'b0);

        cpu_read(3'd2);
        cpu_write(3'd0, 8'h00);
        cpu_write(3'd5, 8'h00);
        cpu_write(3'd5, 8'hEF);
        strobe(1'b0, 1'b0, 1'b1, 1'b1);
        expect_out("load_73a0", 16'h73A0, 3'd0, 1'b0);
        strobe(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("v_scroll_y29", 16'h0800, 3'd0, 1'b0);

        cpu_write(3'd5, 8'h00);
        cpu_write(3'd5, 8'hFF);
        strobe(1'b0, 1'b0, 1'b1, 1'b1);
        strobe(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("v_scroll_y31", 16'h0000, 3'd0, 1'b0);

        cpu_write(3'd0, 8'h02);
        cpu_write(3'd5, 8'h00);
        cpu_write(3'd5, 8'hFF);
        strobe(1'b0, 1'b0, 1'b1, 1'b1);
        cpu_write(3'd0, 8'h01);
        cpu_write(3'd5, 8'hF8);
        cpu_write(3'd5, 8'h00);
        strobe(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("h_update", 16'h7FFF, 3'd0, 1'b0);
        strobe(1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("h_update_over_h_scroll", 16'h7FFF, 3'd0, 1'b0);

        cpu_read(3'd2);
        cpu_write(3'd5, 8'h08);
        cpu_read(3'd2);
        cpu_write(3'd5, 8'h10);
        expect_out("status_clears_w", 16'h7FFF, 3'd0, 1'b1);
        strobe(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("status_t_coarse_x", 16'h7FE2, 3'd0, 1'b1);

        cpu_read(3'd2);
        cpu_write(3'd6, 8'h3F);
        reset_cycle();
        expect_out("mid_reset", 16'h0000, 3'd0, 1'b0);
        cpu_write(3'd6, 8'h12);
        cpu_write(3'd6, 8'h34);
        expect_out("addr_after_reset", 16'h1234, 3'd0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            bit r, ce, wr, rd, ren, rend;
            r    = ($urandom_range(0, 199) == 0);
            ce   = ($urandom_range(0, 3) != 0);
            wr   = ($urandom_range(0, 5) == 0);
            rd   = ($urandom_range(0, 5) == 0);
            ren  = ($urandom_range(0, 3) != 0);
            rend = ren && ($urandom_range(0, 1) == 1);
            step(r, ce, 3'($urandom_range(0, 7)), wr, rd, 8'($urandom_range(0, 255)),
                 ren, rend,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
